// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: MM:SS BCD stopwatch timekeeping and mode controller.
// Runs an IDLE/RUN/PAUSED/ADJUST state machine from debounced button pulses
// and drives the BCD digit inputs of the display multiplexer.
// Optional macro STOPWATCH_BLINK_EN builds the adjust-mode blink phase that
// drives blink_mask; without it blink_mask is tied to zero.

module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int ADJ_DIV  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       wrap,
  output logic [3:0] blink_mask
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ADJ_DIV > 2) ? $clog2(ADJ_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ADJ_LAST  = AW'(ADJ_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, ADJUST} state_t;

  state_t        state, nxt_state;
  logic [PW-1:0] presc, nxt_presc;
  logic [AW-1:0] adj_cnt, nxt_adj_cnt;
  logic [3:0]    nxt_d0, nxt_d1, nxt_d2, nxt_d3;
  logic          nxt_wrap;
  logic          adj_div_wrap;
  logic [3:0]    nxt_blink;
  logic [7:0]    sec_inc, min_inc;

  // Two-digit BCD increment modulo 60 (tens 0-5, ones 0-9)
  function automatic logic [7:0] inc60(input logic [3:0] tens, input logic [3:0] ones);
    if (ones == 4'd9) begin
      if (tens == 4'd5) return 8'h00;
      else return {tens + 4'd1, 4'd0};
    end else begin
      return {tens, ones + 4'd1};
    end
  endfunction

  assign sec_inc = inc60(d1, d0);
  assign min_inc = inc60(d3, d2);

  // Next-state, count, prescaler and adjust-divider decisions
  always_comb begin
    nxt_state    = state;
    nxt_presc    = presc;
    nxt_adj_cnt  = adj_cnt;
    nxt_d0       = d0;
    nxt_d1       = d1;
    nxt_d2       = d2;
    nxt_d3       = d3;
    nxt_wrap     = 1'b0;
    adj_div_wrap = 1'b0;
    case (state)
      IDLE: begin
        if (btn_clear) begin
          nxt_state = IDLE;
        end else if (btn_start) begin
          nxt_state = RUN;
        end else if (adj) begin
          nxt_state   = ADJUST;
          nxt_adj_cnt = '0;
        end
      end
      RUN: begin
        if (btn_clear) begin
          nxt_state = IDLE;
          nxt_presc = '0;
          {nxt_d3, nxt_d2, nxt_d1, nxt_d0} = 16'h0000;
        end else if (btn_start) begin
          nxt_state = PAUSED;
        end else if (presc == TICK_LAST) begin
          nxt_presc        = '0;
          {nxt_d1, nxt_d0} = sec_inc;
          if (d1 == 4'd5 && d0 == 4'd9) begin
            {nxt_d3, nxt_d2} = min_inc;
            nxt_wrap         = (d3 == 4'd5 && d2 == 4'd9);
          end
        end else begin
          nxt_presc = presc + 1'b1;
        end
      end
      PAUSED: begin
        if (btn_clear) begin
          nxt_state = IDLE;
          nxt_presc = '0;
          {nxt_d3, nxt_d2, nxt_d1, nxt_d0} = 16'h0000;
        end else if (btn_start) begin
          nxt_state = RUN;
        end else if (adj) begin
          nxt_state   = ADJUST;
          nxt_adj_cnt = '0;
        end
      end
      ADJUST: begin
        if (!btn_clear && !adj) begin
          nxt_state = PAUSED;
        end else begin
          if (adj_cnt == ADJ_LAST) begin
            nxt_adj_cnt  = '0;
            adj_div_wrap = 1'b1;
          end else begin
            nxt_adj_cnt = adj_cnt + 1'b1;
          end
          if (btn_clear) begin
            {nxt_d3, nxt_d2, nxt_d1, nxt_d0} = 16'h0000;
          end else if (adj_div_wrap) begin
            if (sel) {nxt_d3, nxt_d2} = min_inc;
            else     {nxt_d1, nxt_d0} = sec_inc;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

`ifdef STOPWATCH_BLINK_EN
  logic phase, nxt_phase;

  // Blink phase restarts at 0 on entering ADJUST and toggles on each divider wrap
  always_comb begin
    nxt_phase = 1'b0;
    nxt_blink = 4'b0000;
    if (state == ADJUST && nxt_state == ADJUST)
      nxt_phase = adj_div_wrap ? ~phase : phase;
    if (nxt_state == ADJUST && nxt_phase)
      nxt_blink = sel ? 4'b1100 : 4'b0011;
  end
`else
  assign nxt_blink = 4'b0000;
`endif

  // State, count and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      presc      <= '0;
      adj_cnt    <= '0;
      d0         <= 4'd0;
      d1         <= 4'd0;
      d2         <= 4'd0;
      d3         <= 4'd0;
      running    <= 1'b0;
      wrap       <= 1'b0;
      blink_mask <= 4'b0000;
`ifdef STOPWATCH_BLINK_EN
      phase      <= 1'b0;
`endif
    end else begin
      state      <= nxt_state;
      presc      <= nxt_presc;
      adj_cnt    <= nxt_adj_cnt;
      d0         <= nxt_d0;
      d1         <= nxt_d1;
      d2         <= nxt_d2;
      d3         <= nxt_d3;
      running    <= (nxt_state == RUN);
      wrap       <= nxt_wrap;
      blink_mask <= nxt_blink;
`ifdef STOPWATCH_BLINK_EN
      phase      <= nxt_phase;
`endif
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed self-checking bench for stopwatch_ctrl with
// TICK_DIV=4 and ADJ_DIV=2. Blink expectations follow STOPWATCH_BLINK_EN.

module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] d0, d1, d2, d3;
  logic       running, wrap;
  logic [3:0] blink_mask;

  int compared = 0;
  int mismatched = 0;

`ifdef STOPWATCH_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  stopwatch_ctrl #(.TICK_DIV(4), .ADJ_DIV(2)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
    .adj(adj), .sel(sel), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .running(running), .wrap(wrap), .blink_mask(blink_mask)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic        c;
    logic        a;
    logic        se;
    logic [15:0] cnt;
    logic        run;
    logic        wrp;
    logic [3:0]  blk;
  } vec_t;

  vec_t vecs [32];

  function automatic logic [3:0] blk(input logic [3:0] pattern);
    return BLINK_ON ? pattern : 4'b0000;
  endfunction

  task automatic apply_stimulus(input logic s, input logic c, input logic a, input logic se);
    btn_start = s;
    btn_clear = c;
    adj       = a;
    sel       = se;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic a, input logic se);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, a, se);
  endtask

  task automatic check_output(input string name, input logic [15:0] cnt, input logic r,
                              input logic w, input logic [3:0] b);
    logic [21:0] got, want;
    got  = {d3, d2, d1, d0, running, wrap, blink_mask};
    want = {cnt, r, w, b};
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got cnt=%h running=%b wrap=%b blink=%b, expected cnt=%h running=%b wrap=%b blink=%b",
               name, got[21:6], got[5], got[4], got[3:0], cnt, r, w, b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    btn_start = 1'b0; btn_clear = 1'b0; adj = 1'b0; sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Fields: start, clear, adj, sel, expected MM:SS, running, wrap, blink pattern
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 4'b0000};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 4'b0000};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 4'b0000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 4'b0000};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 4'b0000};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 4'b0000};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 4'b0000};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 4'b0000};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 4'b0000};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 4'b0011};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 4'b1100};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0101, 1'b0, 1'b0, 4'b0000};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b0, 4'b0000};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b1, 1'b0, 4'b0000};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b1, 1'b0, 4'b0000};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b1, 1'b0, 4'b0000};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b1, 1'b0, 4'b0000};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0102, 1'b1, 1'b0, 4'b0000};
    vecs[26] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000};
    vecs[27] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000};
    vecs[28] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000};
    vecs[29] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000};
    vecs[30] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000};
    vecs[31] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000};

    // Reset state, before and after release
    #3;
    check_output("reset_async", 16'h0000, 1'b0, 1'b0, 4'b0000);
    do_reset();

    // Table-driven vectors, one clock per row
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(vecs[i].s, vecs[i].c, vecs[i].a, vecs[i].se);
      check_output($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].run, vecs[i].wrp, blk(vecs[i].blk));
    end

    // 40 cycles of RUN advance ten seconds
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(40, 1'b0, 1'b0);
    check_output("run40", 16'h0010, 1'b1, 1'b0, 4'b0000);

    // Adjust to 59:58, exit, run through the 59:59 -> 00:00 roll
    do_reset();
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycles(118, 1'b1, 1'b1);
    check_output("adj_min59", 16'h5900, 1'b0, 1'b0, blk(4'b1100));
    idle_cycles(116, 1'b1, 1'b0);
    check_output("adj_5958", 16'h5958, 1'b0, 1'b0, blk(4'b0011));
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("adj_exit", 16'h5958, 1'b0, 1'b0, 4'b0000);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("roll_start", 16'h5958, 1'b1, 1'b0, 4'b0000);
    idle_cycles(4, 1'b0, 1'b0);
    check_output("roll_5959", 16'h5959, 1'b1, 1'b0, 4'b0000);
    idle_cycles(3, 1'b0, 1'b0);
    check_output("roll_pre", 16'h5959, 1'b1, 1'b0, 4'b0000);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("roll_wrap", 16'h0000, 1'b1, 1'b1, 4'b0000);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("roll_after", 16'h0000, 1'b1, 1'b0, 4'b0000);

    // Simultaneous start and clear at 00:07 returns to IDLE
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(28, 1'b0, 1'b0);
    check_output("run_0007", 16'h0007, 1'b1, 1'b0, 4'b0000);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check_output("start_clear", 16'h0000, 1'b0, 1'b0, 4'b0000);
    idle_cycles(5, 1'b0, 1'b0);
    check_output("idle_hold", 16'h0000, 1'b0, 1'b0, 4'b0000);

    // Minutes adjust from IDLE with blink pattern per cycle
    do_reset();
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    check_output("adjm_e0", 16'h0000, 1'b0, 1'b0, 4'b0000);
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
      check_output($sformatf("adjm_e%0d", i), {4'h0, 4'(i / 2), 8'h00}, 1'b0, 1'b0,
                   blk(((i / 2) % 2 == 1) ? 4'b1100 : 4'b0000));
    end

    // Minutes roll 59 -> 00 in adjust without wrap, then exit holds count
    do_reset();
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycles(118, 1'b1, 1'b1);
    check_output("m59", 16'h5900, 1'b0, 1'b0, blk(4'b1100));
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    check_output("m59_half", 16'h5900, 1'b0, 1'b0, blk(4'b1100));
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    check_output("m59_roll", 16'h0000, 1'b0, 1'b0, 4'b0000);
    idle_cycles(2, 1'b1, 1'b0);
    check_output("s_inc", 16'h0001, 1'b0, 1'b0, blk(4'b0011));
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("to_paused", 16'h0001, 1'b0, 1'b0, 4'b0000);
    idle_cycles(3, 1'b0, 1'b0);
    check_output("paused_hold", 16'h0001, 1'b0, 1'b0, 4'b0000);

    // Asynchronous reset while running at 12:34
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(3016, 1'b0, 1'b0);
    check_output("run_1234", 16'h1234, 1'b1, 1'b0, 4'b0000);
    #2;
    rst = 1'b0;
    #1;
    check_output("async_rst", 16'h0000, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("post_rst", 16'h0000, 1'b0, 1'b0, 4'b0000);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(4, 1'b0, 1'b0);
    check_output("post_rst_run", 16'h0001, 1'b1, 1'b0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
